drnn_out_capture: RTL and testbench

Stream-side consumer for the EdgeDRNN output interface (`m_out_axis_*`). It accepts packed hidden-state beats of `NUM_PE` lanes and stores one frame (one timestep, delimited by `tlast`) per bank in a two-bank ping-pong buffer. The downstream reader drains completed frames at its own rate through a synchronous read port. The block sits between `edgedrnn` and the host/DMA readout path, and it also serves as the bench-side sink in place of an always-ready `tready`.

---
 rtl/drnn_out_pkg.sv | 14 +
 rtl/drnn_out_bank_ram.sv | 30 +++
 rtl/drnn_out_capture.sv | 114 +++++++++++
 tb/tb_drnn_out_capture.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drnn_out_pkg.sv
// Shared types and sizing for the EdgeDRNN output capture block.
// Checksum support is enabled by defining DRNN_OUT_CHKSUM_EN.
package drnn_out_pkg;
    localparam int NUM_PE        = 8;
    localparam int ACT_BW        = 16;
    localparam int LAYER_SIZE_BW = 10;
    localparam int DEPTH         = (2 ** LAYER_SIZE_BW) / NUM_PE;
    localparam int ADDR_BW       = $clog2(DEPTH);
    localparam int LEN_BW        = ADDR_BW + 1;
    localparam int BEAT_BW       = NUM_PE * ACT_BW;

    typedef logic signed [ACT_BW-1:0] act_t;
    typedef act_t [NUM_PE-1:0] beat_t;
endpackage

// File: rtl/drnn_out_bank_ram.sv
// Two-bank beat storage: one write port, one registered read port, addressed {bank, index}.
module drnn_out_bank_ram
    import drnn_out_pkg::*;
(
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic               we,
    input  logic [ADDR_BW:0]   waddr,
    input  logic [BEAT_BW-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_BW:0]   raddr,
    output logic [BEAT_BW-1:0] rdata
);
    logic [BEAT_BW-1:0] mem [0:2*DEPTH-1];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge s_axi_aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/drnn_out_capture.sv
// Ping-pong frame capture for the EdgeDRNN output stream with a synchronous drain port.
// Define DRNN_OUT_CHKSUM_EN to add per-bank lane-wise XOR checksums.
module drnn_out_capture
    import drnn_out_pkg::*;
(
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [BEAT_BW-1:0] s_axis_tdata,
    input  logic               s_axis_tlast,
    input  logic               rd_en,
    input  logic [ADDR_BW-1:0] rd_addr,
    output logic [BEAT_BW-1:0] rd_data,
    output logic               rd_valid,
    output logic               frame_avail,
    output logic [LEN_BW-1:0]  frame_len,
    input  logic               frame_release,
    output logic               frame_done,
    output logic [31:0]        timestep_cnt,
    output logic               err_overflow,
    output logic [BEAT_BW-1:0] frame_chksum
);
    logic               wr_bank;
    logic               rd_bank;
    logic [1:0]         bank_full;
    logic [ADDR_BW-1:0] beat_cnt;
    logic [LEN_BW-1:0]  len [2];

    logic accept;
    logic last_slot;
    logic frame_end;
    logic release_ok;

    // A beat transfers on any cycle where tvalid and tready are both high; tready
    // depends only on registered bank state, so it never looks at tvalid.
    assign s_axis_tready = ~bank_full[wr_bank];
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign last_slot     = (beat_cnt == ADDR_BW'(DEPTH - 1));
    assign frame_end     = accept & (s_axis_tlast | last_slot);
    assign release_ok    = frame_release & bank_full[rd_bank];
    assign frame_avail   = bank_full[rd_bank];
    assign frame_len     = len[rd_bank];

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            bank_full    <= 2'b00;
            beat_cnt     <= '0;
            len[0]       <= '0;
            len[1]       <= '0;
            frame_done   <= 1'b0;
            timestep_cnt <= '0;
            err_overflow <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            frame_done <= frame_end;
            rd_valid   <= rd_en;
            if (accept) begin
                beat_cnt <= frame_end ? '0 : beat_cnt + 1'b1;
            end
            if (frame_end) begin
                bank_full[wr_bank] <= 1'b1;
                len[wr_bank]       <= LEN_BW'(beat_cnt) + 1'b1;
                wr_bank            <= ~wr_bank;
                timestep_cnt       <= timestep_cnt + 32'd1;
            end
            if (accept && last_slot && !s_axis_tlast) begin
                err_overflow <= 1'b1;
            end
            // A release can only hit the bank opposite a same-cycle frame end.
            if (release_ok) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    drnn_out_bank_ram u_ram (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .we            (accept),
        .waddr         ({wr_bank, beat_cnt}),
        .wdata         (s_axis_tdata),
        .re            (rd_en),
        .raddr         ({rd_bank, rd_addr}),
        .rdata         (rd_data)
    );

`ifdef DRNN_OUT_CHKSUM_EN
    logic [BEAT_BW-1:0] chk_acc;
    logic [BEAT_BW-1:0] chk [2];

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            chk_acc <= '0;
            chk[0]  <= '0;
            chk[1]  <= '0;
        end else if (accept) begin
            if (frame_end) begin
                chk[wr_bank] <= chk_acc ^ s_axis_tdata;
                chk_acc      <= '0;
            end else begin
                chk_acc <= chk_acc ^ s_axis_tdata;
            end
        end
    end

    assign frame_chksum = chk[rd_bank];
`else
    assign frame_chksum = '0;
`endif
endmodule

// File: tb/tb_drnn_out_capture.sv
// Randomised scoreboard bench for drnn_out_capture against a frame-queue reference model.
module tb_drnn_out_capture;
    import drnn_out_pkg::*;

    logic               s_axi_aclk = 1'b0;
    logic               s_axi_aresetn;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [BEAT_BW-1:0] s_axis_tdata;
    logic               s_axis_tlast;
    logic               rd_en;
    logic [ADDR_BW-1:0] rd_addr;
    logic [BEAT_BW-1:0] rd_data;
    logic               rd_valid;
    logic               frame_avail;
    logic [LEN_BW-1:0]  frame_len;
    logic               frame_release;
    logic               frame_done;
    logic [31:0]        timestep_cnt;
    logic               err_overflow;
    logic [BEAT_BW-1:0] frame_chksum;

    drnn_out_capture dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .frame_avail   (frame_avail),
        .frame_len     (frame_len),
        .frame_release (frame_release),
        .frame_done    (frame_done),
        .timestep_cnt  (timestep_cnt),
        .err_overflow  (err_overflow),
        .frame_chksum  (frame_chksum)
    );

    // clock / reset
    always #5 s_axi_aclk = ~s_axi_aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    // scoreboard and reference model: completed frames are kept oldest-first
    logic [BEAT_BW-1:0] exp_q[$];
    logic [BEAT_BW-1:0] m_cur[$];
    logic [BEAT_BW-1:0] m_data[$];
    int                 m_len[$];
    logic [BEAT_BW-1:0] m_chk[$];
    int                 m_count;
    bit                 m_ovf;

    task automatic check(input string name, input logic [BEAT_BW-1:0] act,
                         input logic [BEAT_BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BEAT_BW-1:0] rand_beat();
        logic [BEAT_BW-1:0] b;
        for (int i = 0; i < BEAT_BW / 32; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [BEAT_BW-1:0] lanes(input logic [ACT_BW-1:0] v);
        return {NUM_PE{v}};
    endfunction

    task automatic model_clear();
        m_cur.delete(); m_data.delete(); m_len.delete(); m_chk.delete();
        m_count = 0; m_ovf = 0; done_seen = 0;
    endtask

    task automatic model_release();
        if (m_len.size() > 0) begin
            for (int i = 0; i < m_len[0]; i++) void'(m_data.pop_front());
            void'(m_len.pop_front());
            void'(m_chk.pop_front());
        end
    endtask

    task automatic model_beat(input logic [BEAT_BW-1:0] d, input bit last);
        logic [BEAT_BW-1:0] x;
        m_cur.push_back(d);
        if (last || m_cur.size() == DEPTH) begin
            if (!last) m_ovf = 1;
            x = '0;
            foreach (m_cur[i]) begin
                m_data.push_back(m_cur[i]);
                x ^= m_cur[i];
            end
            m_len.push_back(m_cur.size());
            m_chk.push_back(x);
            m_cur.delete();
            m_count++;
        end
    endtask

    // monitor: pops expected read data whenever the DUT presents rd_valid
    initial begin
        forever begin
            @(negedge s_axi_aclk);
            if (rd_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h expected no read", rd_data);
                end else begin
                    logic [BEAT_BW-1:0] e;
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        n_fail++;
                        $display("FAIL rd_data: got %h expected %h", rd_data, e);
                    end
                end
            end
            if (frame_done) done_seen++;
        end
    end

    // driver tasks (all start and end at posedge + 1)
    task automatic idle(input int n);
        repeat (n) begin @(posedge s_axi_aclk); #1; end
    endtask

    task automatic send_beat(input logic [BEAT_BW-1:0] d, input bit last, input bit rel);
        int waited = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
        while (!s_axis_tready && waited < 300) begin
            @(posedge s_axi_aclk); #1; waited++;
        end
        if (!s_axis_tready) begin
            n_tests++; n_fail++;
            $display("FAIL tready_timeout: got 0 expected 1");
            s_axis_tvalid = 1'b0;
            return;
        end
        frame_release = rel;
        @(posedge s_axi_aclk);
        if (rel) model_release();
        model_beat(d, last);
        #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; frame_release = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit with_last);
        for (int i = 0; i < n; i++) send_beat(rand_beat(), with_last && (i == n - 1), 1'b0);
    endtask

    task automatic do_release();
        frame_release = 1'b1;
        @(posedge s_axi_aclk);
        model_release();
        #1;
        frame_release = 1'b0;
    endtask

    task automatic read_beats(input int n);
        for (int a = 0; a < n; a++) begin
            if (m_len.size() > 0 && a < m_len[0]) begin
                rd_en = 1'b1; rd_addr = ADDR_BW'(a);
                exp_q.push_back(m_data[a]);
                @(posedge s_axi_aclk); #1;
            end
        end
        rd_en = 1'b0;
        idle(1);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_tready"}, BEAT_BW'(s_axis_tready), BEAT_BW'(m_len.size() < 2));
        check({tag, "_avail"}, BEAT_BW'(frame_avail), BEAT_BW'(m_len.size() > 0));
        if (m_len.size() > 0) check({tag, "_len"}, BEAT_BW'(frame_len), BEAT_BW'(m_len[0]));
        check({tag, "_tscnt"}, BEAT_BW'(timestep_cnt), BEAT_BW'(m_count));
        check({tag, "_ovf"}, BEAT_BW'(err_overflow), BEAT_BW'(m_ovf));
`ifdef DRNN_OUT_CHKSUM_EN
        if (m_len.size() > 0) check({tag, "_chksum"}, frame_chksum, m_chk[0]);
`else
        check({tag, "_chksum"}, frame_chksum, '0);
`endif
    endtask

    task automatic check_done(input string tag);
        idle(1);
        check({tag, "_done_pulses"}, BEAT_BW'(done_seen), BEAT_BW'(m_count));
    endtask

    task automatic apply_reset();
        s_axi_aresetn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        rd_en = 1'b0; rd_addr = '0; frame_release = 1'b0;
        repeat (2) @(posedge s_axi_aclk);
        #1;
        model_clear();
        check("rst_tready", BEAT_BW'(s_axis_tready), BEAT_BW'(1));
        check("rst_rd_valid", BEAT_BW'(rd_valid), '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_avail", BEAT_BW'(frame_avail), '0);
        check("rst_len", BEAT_BW'(frame_len), '0);
        check("rst_done", BEAT_BW'(frame_done), '0);
        check("rst_tscnt", BEAT_BW'(timestep_cnt), '0);
        check("rst_ovf", BEAT_BW'(err_overflow), '0);
        check("rst_chksum", frame_chksum, '0);
        s_axi_aresetn = 1'b1;
        idle(1);
    endtask

    initial begin
        apply_reset();

        // four ramp beats closing one short frame
        for (int i = 1; i <= 4; i++) send_beat(lanes(ACT_BW'(i)), i == 4, 1'b0);
        check_state("ramp");
        check("ramp_len_const", BEAT_BW'(frame_len), BEAT_BW'(4));
        check_done("ramp");
        read_beats(4);
        do_release();

        // two full frames fill both banks; the third waits for a release
        send_frame(DEPTH, 1'b1);
        check_state("full_f1");
        send_frame(DEPTH, 1'b1);
        check_state("full_f2");
        check("bp_tready_low", BEAT_BW'(s_axis_tready), '0);
        idle(3);
        check("bp_tready_held", BEAT_BW'(s_axis_tready), '0);
        do_release();
        check("rel_tready_high", BEAT_BW'(s_axis_tready), BEAT_BW'(1));
        send_frame(DEPTH, 1'b1);
        check_state("full_f3");
        check_done("full");
        read_beats(5);
        do_release();
        read_beats(DEPTH);
        do_release();
        check_state("full_drained");

        // 130 beats, tlast only on the last: forced end at 128, then a 2-beat frame
        send_frame(DEPTH, 1'b0);
        check_state("ovf_forced");
        check("ovf_flag", BEAT_BW'(err_overflow), BEAT_BW'(1));
        check("ovf_len", BEAT_BW'(frame_len), BEAT_BW'(DEPTH));
        send_frame(2, 1'b1);
        do_release();
        check_state("ovf_tail");
        check("ovf_tail_len", BEAT_BW'(frame_len), BEAT_BW'(2));
        read_beats(2);
        do_release();

        // frame end coincident with release of the previous frame
        send_frame(3, 1'b1);
        send_beat(rand_beat(), 1'b0, 1'b0);
        send_beat(rand_beat(), 1'b1, 1'b1);
        check_state("coinc");
        check_done("coinc");
        read_beats(2);
        do_release();
        check_state("coinc_drained");

        // randomised traffic: variable frame sizes, reads and releases
        for (int it = 0; it < 30; it++) begin
            if (m_len.size() == 2 || $urandom_range(0, 2) == 0) do_release();
            send_frame($urandom_range(1, 12), 1'b1);
            check_state("rand");
            if ($urandom_range(0, 1) == 1) read_beats($urandom_range(1, 12));
        end
        check_done("rand");
        while (m_len.size() > 0) do_release();

        // reset in the middle of a frame
        send_frame(50, 1'b0);
        apply_reset();
        send_frame(3, 1'b1);
        check_state("post_rst");
        read_beats(3);
        do_release();

        // checksum of a two-beat frame
        send_beat(lanes(16'h00FF), 1'b0, 1'b0);
        send_beat(lanes(16'h0F0F), 1'b1, 1'b0);
        check_state("chk");
`ifdef DRNN_OUT_CHKSUM_EN
        check("chk_value", frame_chksum, lanes(16'h0FF0));
`else
        check("chk_value", frame_chksum, '0);
`endif

        idle(3);
        check("exp_q_drained", BEAT_BW'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
